// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and vector defaults for the interrupt front-end
//
// Contents:
//   int_kind_t   : kind of service sequence currently tracked
//   int_state_t  : Idle / Service state of the front-end
//   VEC_*_DEF    : default vector base addresses
package int_ctrl_pkg;

  typedef enum logic [2:0] {
    IntNone = 3'd0,
    IntRst  = 3'd1,
    IntNmi  = 3'd2,
    IntIrq  = 3'd3,
    IntBrk  = 3'd4
  } int_kind_t;

  typedef enum logic {
    IntIdle    = 1'b0,
    IntService = 1'b1
  } int_state_t;

  localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
  localparam logic [15:0] VEC_RST_DEF = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;

endpackage

// File: rtl/sys_if.sv
// rtl/sys_if.sv - system clock and reset bundle
//
// Signals:
//   clk     : system clock
//   n_reset : synchronous active-low reset
interface sys_if;
  logic clk;
  logic n_reset;

  modport sink (input clk, input n_reset);
endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - single-bit multi-flop synchroniser with reset value
//
// Ports:
//   clk     : destination clock
//   n_reset : synchronous active-low reset, loads RST_VAL into every stage
//   d       : asynchronous input
//   q       : synchronised output, STAGES cycles after d
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - reset/NMI/IRQ/BRK arbitration front-end for the CPU sequencer
//
// Ports:
//   sys        : clock and synchronous active-low reset
//   n_nmi      : NMI pin, active-low, edge-triggered, asynchronous
//   n_irq      : IRQ pin, active-low level, asynchronous
//   p_i        : status I flag (masks IRQ)
//   fetch      : sequencer at an instruction boundary
//   brk_op     : decoded opcode is BRK (Decode cycle)
//   vec_rd     : sequencer reading the vector low byte
//   seq_ack    : vector high byte loaded, service complete
//   int_inject : force IR to $00 and inhibit pc_inc (combinational, fetch cycle)
//   int_vec    : vector base address
//   int_b      : B bit to push (1 only for BRK)
//   int_kind   : kind currently in service
//   int_busy   : service sequence in progress
//   int_set_i  : one-cycle pulse to set the I flag
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_NMI     = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RST     = VEC_RST_DEF,
  parameter logic [15:0] VEC_IRQ     = VEC_IRQ_DEF
) (
  sys_if.sink        sys,
  input  logic       n_nmi,
  input  logic       n_irq,
  input  logic       p_i,
  input  logic       fetch,
  input  logic       brk_op,
  input  logic       vec_rd,
  input  logic       seq_ack,
  output logic       int_inject,
  output logic [15:0] int_vec,
  output logic       int_b,
  output int_kind_t  int_kind,
  output logic       int_busy,
  output logic       int_set_i
);

  logic       n_nmi_s;
  logic       n_irq_s;
  logic       nmi_prev;
  logic       nmi_fall;
  logic       rst_pend;
  logic       nmi_pend;
  logic       irq_req;
  logic       frozen;

  int_state_t  state, state_d;
  int_kind_t   kind_d;
  logic        b_d;
  logic [15:0] vec_d;
  logic        frozen_d;
  logic        inject;
  logic        set_i;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nmi (
    .clk     (sys.clk),
    .n_reset (sys.n_reset),
    .d       (n_nmi),
    .q       (n_nmi_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_irq (
    .clk     (sys.clk),
    .n_reset (sys.n_reset),
    .d       (n_irq),
    .q       (n_irq_s)
  );

  assign nmi_fall = nmi_prev & ~n_nmi_s;
  assign irq_req  = ~n_irq_s & ~p_i;

  always_comb begin
    state_d  = state;
    kind_d   = int_kind;
    b_d      = int_b;
    vec_d    = int_vec;
    frozen_d = frozen;
    inject   = 1'b0;
    set_i    = 1'b0;
    case (state)
      IntIdle: begin
        if (fetch && (rst_pend || nmi_pend || irq_req)) begin
          inject   = 1'b1;
          state_d  = IntService;
          b_d      = 1'b0;
          frozen_d = 1'b0;
          if (rst_pend) begin
            kind_d = IntRst;
            vec_d  = VEC_RST;
          end else if (nmi_pend) begin
            kind_d = IntNmi;
            vec_d  = VEC_NMI;
          end else begin
            kind_d = IntIrq;
            vec_d  = VEC_IRQ;
          end
        end else if (brk_op) begin
          state_d  = IntService;
          kind_d   = IntBrk;
          b_d      = 1'b1;
          vec_d    = VEC_IRQ;
          frozen_d = 1'b0;
        end
      end
      IntService: begin
        // A pending NMI steals an IRQ/BRK sequence until the vector is read;
        // the pushed B bit keeps the original BRK identity.
        if (!frozen && nmi_pend && (int_kind == IntIrq || int_kind == IntBrk)) begin
          kind_d = IntNmi;
          vec_d  = VEC_NMI;
        end
        if (vec_rd) begin
          frozen_d = 1'b1;
        end
        if (seq_ack) begin
          set_i    = 1'b1;
          state_d  = IntIdle;
          kind_d   = IntNone;
          b_d      = 1'b0;
          frozen_d = 1'b0;
        end
      end
      default: state_d = IntIdle;
    endcase
  end

  always_ff @(posedge sys.clk) begin
    if (!sys.n_reset) begin
      state    <= IntIdle;
      int_kind <= IntNone;
      int_b    <= 1'b0;
      int_vec  <= VEC_RST;
      frozen   <= 1'b0;
      nmi_prev <= 1'b1;
      rst_pend <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      state    <= state_d;
      int_kind <= kind_d;
      int_b    <= b_d;
      int_vec  <= vec_d;
      frozen   <= frozen_d;
      nmi_prev <= n_nmi_s;
      if (set_i && int_kind == IntRst) begin
        rst_pend <= 1'b0;
      end
      // New edge wins over a same-cycle acknowledge.
      if (nmi_fall) begin
        nmi_pend <= 1'b1;
      end else if (set_i && int_kind == IntNmi) begin
        nmi_pend <= 1'b0;
      end
    end
  end

  assign int_inject = inject & sys.n_reset;
  assign int_set_i  = set_i & sys.n_reset;
  assign int_busy   = (state == IntService);

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  sys_if sys ();

  logic        n_nmi, n_irq, p_i, fetch, brk_op, vec_rd, seq_ack;
  logic        int_inject, int_b, int_busy, int_set_i;
  logic [15:0] int_vec;
  int_kind_t   int_kind;

  int checks = 0;
  int errors = 0;

  int_ctrl dut (
    .sys        (sys),
    .n_nmi      (n_nmi),
    .n_irq      (n_irq),
    .p_i        (p_i),
    .fetch      (fetch),
    .brk_op     (brk_op),
    .vec_rd     (vec_rd),
    .seq_ack    (seq_ack),
    .int_inject (int_inject),
    .int_vec    (int_vec),
    .int_b      (int_b),
    .int_kind   (int_kind),
    .int_busy   (int_busy),
    .int_set_i  (int_set_i)
  );

  initial sys.clk = 1'b0;
  always #5 sys.clk = ~sys.clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys.clk);
      #1;
    end
  endtask

  // Fetch cycle: check the combinational inject, then step one edge.
  task automatic do_fetch(input string tag, input logic exp_inject);
    fetch = 1'b1;
    #1;
    check(tag, 32'(int_inject), 32'(exp_inject));
    tick(1);
    fetch = 1'b0;
  endtask

  task automatic do_ack(input string tag);
    seq_ack = 1'b1;
    #1;
    check(tag, 32'(int_set_i), 32'd1);
    tick(1);
    seq_ack = 1'b0;
    #1;
    check({tag, "_idle"}, 32'(int_busy), 32'd0);
  endtask

  initial begin
    sys.n_reset = 1'b0;
    n_nmi = 1'b1; n_irq = 1'b1; p_i = 1'b1;
    fetch = 1'b0; brk_op = 1'b0; vec_rd = 1'b0; seq_ack = 1'b0;
    tick(3);

    // Reset state, including inject/set_i gated while reset is held.
    fetch = 1'b1; seq_ack = 1'b1;
    #1;
    check("rst_inject", 32'(int_inject), 32'd0);
    check("rst_set_i",  32'(int_set_i),  32'd0);
    check("rst_vec",    32'(int_vec),    32'hFFFC);
    check("rst_kind",   32'(int_kind),   32'(IntNone));
    check("rst_b",      32'(int_b),      32'd0);
    check("rst_busy",   32'(int_busy),   32'd0);
    fetch = 1'b0; seq_ack = 1'b0;

    // 1: reset vector serviced on the first fetch.
    sys.n_reset = 1'b1;
    do_fetch("t1_inject", 1'b1);
    check("t1_kind", 32'(int_kind), 32'(IntRst));
    check("t1_vec",  32'(int_vec),  32'hFFFC);
    check("t1_busy", 32'(int_busy), 32'd1);
    do_ack("t1_set_i");
    do_fetch("t1_no_repeat", 1'b0);

    // 2: held-low NMI yields exactly one service.
    n_nmi = 1'b0;
    tick(5);
    do_fetch("t2_inject", 1'b1);
    check("t2_kind", 32'(int_kind), 32'(IntNmi));
    check("t2_vec",  32'(int_vec),  32'hFFFA);
    do_ack("t2_set_i");
    tick(45);
    do_fetch("t2_once", 1'b0);
    n_nmi = 1'b1;
    tick(3);

    // 3: IRQ masked by I, taken when unmasked, gone once released.
    n_irq = 1'b0;
    tick(3);
    do_fetch("t3_masked", 1'b0);
    p_i = 1'b0;
    do_fetch("t3_inject", 1'b1);
    check("t3_kind", 32'(int_kind), 32'(IntIrq));
    check("t3_vec",  32'(int_vec),  32'hFFFE);
    check("t3_b",    32'(int_b),    32'd0);
    do_ack("t3_set_i");
    n_irq = 1'b1;
    tick(3);
    do_fetch("t3_released", 1'b0);
    check("t3_busy", 32'(int_busy), 32'd0);

    // 4: BRK hijacked by NMI before vec_rd.
    brk_op = 1'b1;
    #1;
    check("t4_no_inject", 32'(int_inject), 32'd0);
    tick(1);
    brk_op = 1'b0;
    check("t4_kind", 32'(int_kind), 32'(IntBrk));
    check("t4_b",    32'(int_b),    32'd1);
    check("t4_vec",  32'(int_vec),  32'hFFFE);
    check("t4_busy", 32'(int_busy), 32'd1);
    fetch = 1'b1;
    tick(1);
    fetch = 1'b0;
    n_nmi = 1'b0;
    tick(5);
    check("t4_hij_vec",  32'(int_vec),  32'hFFFA);
    check("t4_hij_b",    32'(int_b),    32'd1);
    check("t4_hij_kind", 32'(int_kind), 32'(IntNmi));
    vec_rd = 1'b1;
    tick(1);
    vec_rd = 1'b0;
    do_ack("t4_set_i");
    do_fetch("t4_nmi_clr", 1'b0);
    n_nmi = 1'b1;
    tick(3);

    // 4b: NMI after vec_rd leaves the vector frozen, serviced afterwards.
    brk_op = 1'b1;
    tick(1);
    brk_op = 1'b0;
    vec_rd = 1'b1;
    tick(1);
    vec_rd = 1'b0;
    n_nmi = 1'b0;
    tick(5);
    check("t4b_frozen_vec",  32'(int_vec),  32'hFFFE);
    check("t4b_frozen_kind", 32'(int_kind), 32'(IntBrk));
    do_ack("t4b_set_i");
    do_fetch("t4b_nmi_later", 1'b1);
    check("t4b_kind", 32'(int_kind), 32'(IntNmi));
    do_ack("t4b_ack2");
    n_nmi = 1'b1;
    tick(3);

    // 5: priority RST > NMI > IRQ.
    sys.n_reset = 1'b0;
    tick(1);
    sys.n_reset = 1'b1;
    n_nmi = 1'b0; n_irq = 1'b0; p_i = 1'b0;
    tick(5);
    do_fetch("t5_inj_rst", 1'b1);
    check("t5_kind_rst", 32'(int_kind), 32'(IntRst));
    do_ack("t5_ack_rst");
    do_fetch("t5_inj_nmi", 1'b1);
    check("t5_kind_nmi", 32'(int_kind), 32'(IntNmi));
    do_ack("t5_ack_nmi");
    do_fetch("t5_inj_irq", 1'b1);
    check("t5_kind_irq", 32'(int_kind), 32'(IntIrq));
    check("t5_vec_irq",  32'(int_vec),  32'hFFFE);
    do_ack("t5_ack_irq");
    n_nmi = 1'b1; n_irq = 1'b1; p_i = 1'b1;
    tick(3);

    // 6: reset in the middle of an NMI service.
    n_nmi = 1'b0;
    tick(5);
    do_fetch("t6_inject", 1'b1);
    check("t6_kind", 32'(int_kind), 32'(IntNmi));
    sys.n_reset = 1'b0;
    tick(1);
    sys.n_reset = 1'b1;
    check("t6_busy", 32'(int_busy), 32'd0);
    check("t6_vec",  32'(int_vec),  32'hFFFC);
    do_fetch("t6_inj_rst", 1'b1);
    check("t6_kind_rst", 32'(int_kind), 32'(IntRst));
    check("t6_vec_rst",  32'(int_vec),  32'hFFFC);
    do_ack("t6_ack");
    n_nmi = 1'b1;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
